// File: rtl/stack_ram_responder_if.sv
// rtl/stack_ram_responder_if.sv - start/done transfer ports plus byte-wide RAM port
interface stack_ram_responder_if;
  logic         rd_start;
  logic [15:0]  rd_address;
  logic [15:0]  rd_bytes;
  logic [255:0] rd_q;
  logic         rd_done;
  logic         wr_start;
  logic [15:0]  wr_address;
  logic [15:0]  wr_bytes;
  logic [255:0] wr_data;
  logic         wr_done;
  logic [15:0]  mem_address;
  logic [7:0]   mem_wdata;
  logic         mem_we;
  logic [7:0]   mem_rdata;

  modport slave (
    input  rd_start, rd_address, rd_bytes, wr_start, wr_address, wr_bytes, wr_data, mem_rdata,
    output rd_q, rd_done, wr_done, mem_address, mem_wdata, mem_we
  );

  modport master (
    output rd_start, rd_address, rd_bytes, wr_start, wr_address, wr_bytes, wr_data, mem_rdata,
    input  rd_q, rd_done, wr_done, mem_address, mem_wdata, mem_we
  );
endinterface

// File: rtl/stack_ram_responder.sv
// rtl/stack_ram_responder.sv - splits up-to-32-byte transfers into byte accesses on a 1-cycle-latency RAM
module stack_ram_responder #(
  parameter int MAX_BYTES = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  stack_ram_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, RD_DONE, WR_DONE} state_t;

  state_t       state_q, state_d;
  logic [5:0]   len_q, len_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [255:0] wdata_q, wdata_d;
  logic [255:0] rd_q_q, rd_q_d;
  logic         rd_done_q, rd_done_d;
  logic         wr_done_q, wr_done_d;
  logic         mem_we_q, mem_we_d;
  logic [15:0]  mem_address_q, mem_address_d;
  logic [7:0]   mem_wdata_q, mem_wdata_d;
  logic [5:0]   step;
  logic [4:0]   lane;
  logic [5:0]   rd_len, wr_len;

  function automatic logic [5:0] clamp_len(input logic [15:0] b);
    return (b > 16'(MAX_BYTES)) ? 6'(MAX_BYTES) : b[5:0];
  endfunction

  assign rd_len = clamp_len(bus.rd_bytes);
  assign wr_len = clamp_len(bus.wr_bytes);

  // cnt_q holds the index of the last edge of the transfer; step is the edge being computed
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    wdata_d       = wdata_q;
    rd_q_d        = rd_q_q;
    rd_done_d     = rd_done_q;
    wr_done_d     = wr_done_q;
    mem_we_d      = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    step          = cnt_q + 6'd1;
    lane          = step[4:0] - 5'd2;
    case (state_q)
      IDLE: begin
        if (bus.wr_start) begin
          state_d = WRITE;
          len_d   = wr_len;
          cnt_d   = 6'd0;
          if (wr_len != 6'd0) begin
            mem_we_d      = 1'b1;
            mem_address_d = bus.wr_address;
            mem_wdata_d   = bus.wr_data[255:248];
            wdata_d       = {bus.wr_data[247:0], 8'h00};
          end
        end else if (bus.rd_start) begin
          state_d = READ;
          len_d   = rd_len;
          cnt_d   = 6'd0;
          rd_q_d  = '0;
          if (rd_len != 6'd0) mem_address_d = bus.rd_address;
        end
      end
      READ: begin
        if (!bus.rd_start) begin
          state_d = IDLE;
        end else begin
          cnt_d = step;
          if (step < len_q) mem_address_d = mem_address_q + 16'd1;
          // RAM data lags its address by one edge, so lane i lands at edge i+2
          if (step >= 6'd2) rd_q_d[8'd255 - {lane, 3'b000} -: 8] = bus.mem_rdata;
          if (step == len_q + 6'd1) begin
            state_d   = RD_DONE;
            rd_done_d = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!bus.wr_start) begin
          state_d = IDLE;
        end else begin
          cnt_d = step;
          if (step < len_q) begin
            mem_we_d      = 1'b1;
            mem_address_d = mem_address_q + 16'd1;
            mem_wdata_d   = wdata_q[255:248];
            wdata_d       = {wdata_q[247:0], 8'h00};
          end else begin
            state_d   = WR_DONE;
            wr_done_d = 1'b1;
          end
        end
      end
      RD_DONE: begin
        if (!bus.rd_start) begin
          state_d   = IDLE;
          rd_done_d = 1'b0;
        end
      end
      WR_DONE: begin
        if (!bus.wr_start) begin
          state_d   = IDLE;
          wr_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      len_q         <= '0;
      cnt_q         <= '0;
      wdata_q       <= '0;
      rd_q_q        <= '0;
      rd_done_q     <= 1'b0;
      wr_done_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      wdata_q       <= wdata_d;
      rd_q_q        <= rd_q_d;
      rd_done_q     <= rd_done_d;
      wr_done_q     <= wr_done_d;
      mem_we_q      <= mem_we_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign bus.rd_q        = rd_q_q;
  assign bus.rd_done     = rd_done_q;
  assign bus.wr_done     = wr_done_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_stack_ram_responder.sv
// tb/tb_stack_ram_responder.sv - scoreboard bench for stack_ram_responder with a byte-wide RAM model
module tb_stack_ram_responder;
  logic clock;
  logic reset_n;

  stack_ram_responder_if bus ();

  stack_ram_responder #(.MAX_BYTES(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0]   ram     [0:65535];
  logic [7:0]   ref_mem [0:65535];
  logic [23:0]  wq [$];
  logic [255:0] rq [$];
  bit           abort_mode = 1'b0;
  int           abort_we   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (bus.mem_we) ram[bus.mem_address] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_address];
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      if (abort_mode) begin
        abort_we++;
      end else if (wq.size() == 0) begin
        check("unexpected_we", 256'(bus.mem_address), 256'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = wq.pop_front();
        check("we_addr", 256'(bus.mem_address), 256'(e[23:8]));
        check("we_data", 256'(bus.mem_wdata), 256'(e[7:0]));
      end
    end
  end

  task automatic wait_sig(input bit is_rd, output int edges);
    bit seen;
    edges = 0;
    seen  = 1'b0;
    while (!seen) begin
      @(negedge clock);
      if (is_rd ? bus.rd_done : bus.wr_done) begin
        seen = 1'b1;
      end else begin
        edges++;
        if (edges > 100) begin
          check(is_rd ? "rd_timeout" : "wr_timeout", 256'(0), 256'(1));
          seen = 1'b1;
        end
      end
    end
  endtask

  function automatic int eff_len(input logic [15:0] b);
    return (b > 16'd32) ? 32 : int'(b);
  endfunction

  task automatic push_write(input logic [15:0] addr, input logic [15:0] nbytes, input logic [255:0] data);
    logic [15:0] a;
    for (int i = 0; i < eff_len(nbytes); i++) begin
      a = addr + 16'(i);
      wq.push_back({a, data[255-8*i -: 8]});
      ref_mem[a] = data[255-8*i -: 8];
    end
  endtask

  function automatic logic [255:0] expect_read(input logic [15:0] addr, input logic [15:0] nbytes);
    logic [255:0] exp;
    logic [15:0]  a;
    exp = '0;
    for (int i = 0; i < eff_len(nbytes); i++) begin
      a = addr + 16'(i);
      exp[255-8*i -: 8] = ref_mem[a];
    end
    return exp;
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [15:0] nbytes, input logic [255:0] data, input string tag);
    int n, e;
    n = eff_len(nbytes);
    push_write(addr, nbytes, data);
    bus.wr_address = addr;
    bus.wr_bytes   = nbytes;
    bus.wr_data    = data;
    bus.wr_start   = 1'b1;
    wait_sig(1'b0, e);
    check({tag, "_lat"}, 256'(e), 256'((n == 0) ? 1 : n));
    check({tag, "_drained"}, 256'(wq.size()), 256'(0));
    check({tag, "_we_off"}, 256'(bus.mem_we), 256'(0));
    bus.wr_start = 1'b0;
    @(negedge clock);
    check({tag, "_release"}, 256'(bus.wr_done), 256'(0));
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [15:0] nbytes, input int hold, input string tag);
    int n, e;
    logic [255:0] exp;
    logic [15:0]  addr_before;
    n = eff_len(nbytes);
    rq.push_back(expect_read(addr, nbytes));
    addr_before = bus.mem_address;
    bus.rd_address = addr;
    bus.rd_bytes   = nbytes;
    bus.rd_start   = 1'b1;
    wait_sig(1'b1, e);
    check({tag, "_lat"}, 256'(e), 256'(n + 1));
    exp = (rq.size() != 0) ? rq.pop_front() : '0;
    check({tag, "_q"}, bus.rd_q, exp);
    if (n == 0) check({tag, "_noaccess"}, 256'(bus.mem_address), 256'(addr_before));
    addr_before = bus.mem_address;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check({tag, "_hold_done"}, 256'(bus.rd_done), 256'(1));
      check({tag, "_hold_q"}, bus.rd_q, exp);
      check({tag, "_hold_addr"}, 256'(bus.mem_address), 256'(addr_before));
    end
    bus.rd_start = 1'b0;
    @(negedge clock);
    check({tag, "_release"}, 256'(bus.rd_done), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    int e;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    reset_n        = 1'b0;
    bus.rd_start   = 1'b0;
    bus.rd_address = '0;
    bus.rd_bytes   = '0;
    bus.wr_start   = 1'b0;
    bus.wr_address = '0;
    bus.wr_bytes   = '0;
    bus.wr_data    = '0;
    repeat (2) @(negedge clock);
    check("rst_rd_done", 256'(bus.rd_done), 256'(0));
    check("rst_wr_done", 256'(bus.wr_done), 256'(0));
    check("rst_mem_we", 256'(bus.mem_we), 256'(0));
    check("rst_mem_addr", 256'(bus.mem_address), 256'(0));
    check("rst_rd_q", bus.rd_q, 256'(0));
    reset_n = 1'b1;
    @(negedge clock);

    d = '0;
    d[255:240] = 16'hABCD;
    do_write(16'h0100, 16'd2, d, "wr2");
    do_read(16'h0100, 16'd2, 0, "rd2");

    for (int i = 0; i < 32; i++) d[255-8*i -: 8] = 8'(i);
    do_write(16'h2000, 16'd32, d, "wr32");
    do_read(16'h2000, 16'd32, 0, "rd32");
    do_read(16'h2000, 16'd40, 0, "rd40");

    d = '0;
    d[255:232] = 24'h112233;
    do_write(16'hFFFF, 16'd3, d, "wrwrap");
    do_read(16'hFFFF, 16'd3, 0, "rdwrap");

    do_read(16'h0100, 16'd0, 0, "rdzero");

    // read and write raised together: write first, read after wr_start drops
    d = '0;
    d[255:240] = 16'h5AA5;
    push_write(16'h0200, 16'd2, d);
    rq.push_back(expect_read(16'h0200, 16'd2));
    bus.wr_address = 16'h0200;
    bus.wr_bytes   = 16'd2;
    bus.wr_data    = d;
    bus.rd_address = 16'h0200;
    bus.rd_bytes   = 16'd2;
    bus.wr_start   = 1'b1;
    bus.rd_start   = 1'b1;
    wait_sig(1'b0, e);
    check("coll_wr_lat", 256'(e), 256'(2));
    check("coll_rd_idle", 256'(bus.rd_done), 256'(0));
    bus.wr_start = 1'b0;
    wait_sig(1'b1, e);
    check("coll_rd_lat", 256'(e), 256'(4));
    check("coll_rd_q", bus.rd_q, (rq.size() != 0) ? rq.pop_front() : '0);
    bus.rd_start = 1'b0;
    @(negedge clock);

    do_read(16'h0100, 16'd2, 5, "rdhold");

    abort_mode     = 1'b1;
    abort_we       = 0;
    bus.wr_address = 16'h3000;
    bus.wr_bytes   = 16'd8;
    bus.wr_data    = {8{32'hC0DE_F00D}};
    bus.wr_start   = 1'b1;
    repeat (3) @(negedge clock);
    bus.wr_start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", 256'(bus.wr_done), 256'(0));
    end
    abort_mode = 1'b0;
    check("abort_we_max", 256'(abort_we <= 4), 256'(1));
    check("abort_we_min", 256'(abort_we >= 3), 256'(1));
    check("abort_we_off", 256'(bus.mem_we), 256'(0));

    bus.rd_address = 16'h0100;
    bus.rd_bytes   = 16'd8;
    bus.rd_start   = 1'b1;
    repeat (4) @(negedge clock);
    check("pre_rst_lane0", 256'(bus.rd_q[255:248]), 256'(8'hAB));
    reset_n = 1'b0;
    #1;
    check("mid_rst_rd_q", bus.rd_q, 256'(0));
    check("mid_rst_rd_done", 256'(bus.rd_done), 256'(0));
    check("mid_rst_mem_we", 256'(bus.mem_we), 256'(0));
    check("mid_rst_mem_addr", 256'(bus.mem_address), 256'(0));
    bus.rd_start = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    do_read(16'h2000, 16'd4, 0, "rdpost");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
